// File: rtl/pb_conditioner_if.sv
// ----------------------------------------------------------------------------
// pb_conditioner_if
// Signal bundle between a raw push-button pin and its conditioner.
//   btn_n          raw button pin, active-low, asynchronous to clk
//   btn_level      debounced level, active-high (1 = pressed)
//   press_pulse    one-cycle strobe on btn_level rising
//   release_pulse  one-cycle strobe on btn_level falling
//   repeat_pulse   one-cycle auto-repeat strobe while held (0 if not built)
// Modports:
//   master  drives the pin and consumes the conditioned outputs
//   slave   the conditioner itself
// ----------------------------------------------------------------------------
interface pb_conditioner_if;
  logic btn_n;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  modport master (
    output btn_n,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  btn_n,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/pb_conditioner.sv
// ----------------------------------------------------------------------------
// pb_conditioner
// Front-end for a physical push-button: synchronises the raw active-low pin
// to clk, debounces it, and produces a clean active-high level together with
// one-cycle press/release strobes.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (deassertion synchronised elsewhere)
//   bus    pb_conditioner_if.slave: btn_n in; btn_level, press_pulse,
//          release_pulse, repeat_pulse out
//
// Parameters:
//   SYNC_STAGES      synchroniser depth, 2..4
//   DEBOUNCE_CYCLES  stable cycles required before the level changes, >= 1
//   REPEAT_DELAY     press_pulse to first repeat_pulse (auto-repeat only)
//   REPEAT_PERIOD    spacing of later repeat_pulses (auto-repeat only)
//
// Build option:
//   PB_CONDITIONER_AUTOREPEAT_EN  when defined, repeat_pulse fires while the
//   button is held; otherwise the repeat counter is absent and repeat_pulse
//   is tied to 0.
// ----------------------------------------------------------------------------
module pb_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  pb_conditioner_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("pb_conditioner: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("pb_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("pb_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // --- stage p0: metastability synchroniser (flops preset to "released") ---
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   pressed_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.btn_n};
    end
  end

  assign pressed_p0 = ~sync_p0[SYNC_STAGES-1];

  // --- stage p1: debounce FSM with registered level and strobes ---
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             level_p1;
  logic             press_p1;
  logic             release_p1;

`ifdef PB_CONDITIONER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic             repeat_p1;
  logic             in_hold;
  logic             rel_now;

  assign in_hold = (state == HELD) || (state == DEB_RELEASE);
  // The edge that drops btn_level must not also emit a repeat strobe.
  assign rel_now = (state == DEB_RELEASE) && !pressed_p0 && (cnt == DEB_MAX);
  assign bus.repeat_pulse = repeat_p1;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      level_p1   <= 1'b0;
      press_p1   <= 1'b0;
      release_p1 <= 1'b0;
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
      rpt_cnt    <= '0;
      rpt_first  <= 1'b1;
      repeat_p1  <= 1'b0;
`endif
    end else begin
      press_p1   <= 1'b0;
      release_p1 <= 1'b0;

      // cnt is cleared on every state exit, so it never passes DEB_MAX.
      case (state)
        IDLE: begin
          if (pressed_p0) begin
            state <= DEB_PRESS;
            cnt   <= CNT_W'(1);
          end
        end
        DEB_PRESS: begin
          if (!pressed_p0) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state    <= HELD;
            cnt      <= '0;
            level_p1 <= 1'b1;
            press_p1 <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!pressed_p0) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_W'(1);
          end
        end
        DEB_RELEASE: begin
          if (pressed_p0) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_MAX) begin
            state      <= IDLE;
            cnt        <= '0;
            level_p1   <= 1'b0;
            release_p1 <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

`ifdef PB_CONDITIONER_AUTOREPEAT_EN
      // Counter is held clear outside HELD/DEB_RELEASE, so it starts from 0
      // on the press edge; a count of DLY_LAST then lands exactly
      // REPEAT_DELAY edges after press_pulse.
      repeat_p1 <= 1'b0;
      if (!in_hold || rel_now) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST)) begin
        repeat_p1 <= 1'b1;
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
`endif
    end
  end

  assign bus.btn_level     = level_p1;
  assign bus.press_pulse   = press_p1;
  assign bus.release_pulse = release_p1;

endmodule

// File: tb/tb_pb_conditioner.sv
// ----------------------------------------------------------------------------
// tb_pb_conditioner
// Directed bench for pb_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Stimulus pushes the expected strobes
// (kind and clock-edge number) into a queue; a monitor on the falling edge
// pops and compares every strobe the DUT produces.
// ----------------------------------------------------------------------------
module tb_pb_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int RDLY  = 10;
  localparam int RPER  = 3;
  // btn_n changed on a falling edge after edge N changes btn_level at edge
  // N + 1 (first sampling edge) + SYNC + DEB.
  localparam int LAT   = SYNC + DEB + 1;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_REPEAT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc     = 0;
  int   vectors = 0;
  int   errs    = 0;
  ev_t  exp_q[$];

  pb_conditioner_if bus();

  pb_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int outs();
    return int'({bus.btn_level, bus.press_pulse, bus.release_pulse, bus.repeat_pulse});
  endfunction

  function automatic void push(ev_kind_t k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s cyc=%0d got %0d required %0d", name, cyc, act, req);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_cmp(ev_kind_t k);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL unexpected_%s cyc=%0d got strobe, required none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        errs++;
        $display("FAIL strobe got %s@%0d required %s@%0d", k.name(), cyc, e.kind.name(), e.cyc);
      end
    end
  endtask

  // Monitor: every strobe is checked against the scoreboard.
  always @(negedge clk) begin
    if (bus.press_pulse && bus.release_pulse) begin
      vectors++;
      errs++;
      $display("FAIL press_release_overlap cyc=%0d got both high, required at most one", cyc);
    end
    if (bus.press_pulse)   pop_cmp(EV_PRESS);
    if (bus.release_pulse) pop_cmp(EV_RELEASE);
    if (bus.repeat_pulse)  pop_cmp(EV_REPEAT);
  end

  initial begin
    int n;
    int p;

    // Reset with the button already held.
    bus.btn_n = 1'b0;
    rst_n     = 1'b0;
    step(1);
    chk("reset_outputs", outs(), 0);
    step(2);
    chk("reset_hold_outputs", outs(), 0);

    // Release reset: fresh press after full sync + debounce latency.
    n     = cyc;
    rst_n = 1'b1;
    push(EV_PRESS, n + LAT);
    step(LAT - 1);
    chk("press_level_early", int'(bus.btn_level), 0);
    step(1);
    chk("press_level", int'(bus.btn_level), 1);

    // Stable release.
    n         = cyc;
    bus.btn_n = 1'b1;
    push(EV_RELEASE, n + LAT);
    step(LAT - 1);
    chk("release_level_early", int'(bus.btn_level), 1);
    step(1);
    chk("release_level", int'(bus.btn_level), 0);
    step(1);
    chk("release_pulse_width", outs(), 0);

    // Bounce: 3 low, 2 high, 3 low, high -- never reaches DEB.
    bus.btn_n = 1'b0;
    step(3);
    bus.btn_n = 1'b1;
    step(2);
    bus.btn_n = 1'b0;
    step(3);
    bus.btn_n = 1'b1;
    step(12);
    chk("bounce_level", int'(bus.btn_level), 0);

    // Press, 2-cycle release glitch, long hold (auto-repeat), release.
    n         = cyc;
    bus.btn_n = 1'b0;
    push(EV_PRESS, n + LAT);
    step(LAT);
    p = cyc;
    chk("glitch_press_level", int'(bus.btn_level), 1);
    bus.btn_n = 1'b1;
    step(2);
    bus.btn_n = 1'b0;
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
    for (int k = RDLY; k <= 34; k += RPER) push(EV_REPEAT, p + k);
`endif
    step(10);
    chk("glitch_level_held", int'(bus.btn_level), 1);
    step(17);
    bus.btn_n = 1'b1;
    push(EV_RELEASE, p + 29 + LAT);
    step(LAT);
    chk("hold_release_level", int'(bus.btn_level), 0);

    // Async reset while held: outputs drop without a clock edge.
    n         = cyc;
    bus.btn_n = 1'b0;
    push(EV_PRESS, n + LAT);
    step(LAT);
    chk("pre_reset_level", int'(bus.btn_level), 1);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    step(1);
    n     = cyc;
    rst_n = 1'b1;
    push(EV_PRESS, n + LAT);
    step(LAT);
    chk("post_reset_press_level", int'(bus.btn_level), 1);
    n         = cyc;
    bus.btn_n = 1'b1;
    push(EV_RELEASE, n + LAT);
    step(LAT);
    chk("final_release_level", int'(bus.btn_level), 0);

    step(10);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
- Front-end input stage for every physical push-button in the Tamagotchi.
- Takes the raw active-low FPGA button pin, synchronises it to clk and debounces it.
- Produces a clean active-high level plus one-cycle press/release pulses.
- btn_level drives the downstream long-press/reset detector and the menu logic; pulses drive short-press actions.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the metastability synchroniser; legal range 2..4.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before the level changes (20 ms at 50 MHz); must be ≥1.
- REPEAT_DELAY, 25000000: cycles from press_pulse to the first repeat_pulse (only with the optional feature).
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat_pulses (only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_n  input  1  raw button pin, active-low (0 = pressed), asynchronous to clk.
- btn_level  output  1  debounced button state, active-high (1 = pressed).
- press_pulse  output  1  one-cycle pulse when btn_level rises.
- release_pulse  output  1  one-cycle pulse when btn_level falls.
- repeat_pulse  output  1  one-cycle auto-repeat strobe while held; constant 0 without the optional feature.

Behaviour:
- Reset (rst_n=0, async assert):
  - All synchroniser flops load 1 (released).
  - FSM goes to IDLE, debounce counter = 0.
  - btn_level, press_pulse, release_pulse, repeat_pulse = 0.
  - Deassertion is not synchronised inside this block.
- Synchroniser: SYNC_STAGES-deep shift of btn_n. s = ~(last stage), so s=1 means pressed.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
  - IDLE: btn_level=0. If s=1, go to DEB_PRESS with cnt=1.
  - DEB_PRESS: if s=0, go to IDLE and set cnt=0 (bounce rejected). Else, if cnt==DEBOUNCE_CYCLES, go to HELD, set btn_level<=1, assert press_pulse for one cycle. Otherwise cnt++.
  - HELD: btn_level=1. If s=0, go to DEB_RELEASE with cnt=1.
  - DEB_RELEASE: symmetric to DEB_PRESS. If s=1, return to HELD (no pulses). If cnt==DEBOUNCE_CYCLES with s=0, go to IDLE, set btn_level<=0, assert release_pulse for one cycle.
- Special case DEBOUNCE_CYCLES=1: the transition out of IDLE/HELD and the level change happen on consecutive edges.
- Latency: btn_level changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples a new, stable btn_n value. The matching pulse is registered and coincides with the btn_level change.
- Counter: width $clog2(DEBOUNCE_CYCLES+1). It saturates by construction because it is cleared on every state exit, so there is no wrap-around.
- Pulse rules:
  - press_pulse and release_pulse are never asserted in the same cycle.
  - Each pulse is exactly 1 cycle wide.
  - A bounce of any length shorter than DEBOUNCE_CYCLES produces no pulse and no btn_level change.
- Reset mid-debounce or mid-hold: all outputs return to 0 immediately and no release_pulse is emitted. After reset, a still-held button is debounced again from IDLE and produces a fresh press_pulse.

Optional Feature:
- Macro: PB_CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - A repeat counter runs while the FSM is in HELD or DEB_RELEASE.
  - It is cleared on press_pulse.
  - repeat_pulse fires for one cycle REPEAT_DELAY cycles after press_pulse, then every REPEAT_PERIOD cycles.
  - Leaving to IDLE or reset clears the counter and suppresses pending pulses.
  - repeat_pulse is never coincident with press_pulse.
- Undefined: the repeat counter is not synthesised; repeat_pulse is tied to 0.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset check: rst_n=0 with btn_n=0 → all outputs 0. Release reset, hold btn_n=0 → btn_level=1 and press_pulse=1 at edge 6 after the first sampling edge; press_pulse=0 at edge 7.
- Bounce rejection: btn_n low for 3 cycles, high for 2, low for 3, then high → btn_level stays 0; no pulses ever.
- Release: hold until btn_level=1, then btn_n=1 stable → release_pulse=1 and btn_level=0 exactly 6 edges later; pulse lasts 1 cycle.
- Release glitch: btn_level=1, then btn_n=1 for 2 cycles and back to 0 → btn_level stays 1, release_pulse never fires.
- Async reset mid-hold: btn_level=1, then rst_n=0 for 1 cycle with btn_n still 0 → outputs drop to 0 without a clock edge; no release_pulse; new press_pulse 6 edges after rst_n rises.
- Auto-repeat (with PB_CONDITIONER_AUTOREPEAT_EN): hold 30 cycles after press_pulse → repeat_pulse at +10, +13, +16, … +28 relative to press_pulse. Without the macro, repeat_pulse stays 0 throughout.
